// File: rtl/duty_cycle_meter.sv
// Duty-cycle and period monitor for a clk-synchronous pulse train.
// Publishes per-period measurements, tolerance mismatch, lock, and sticky error/stuck flags.
module duty_cycle_meter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXP_HIGH   = 1,
    parameter int unsigned EXP_PERIOD = 4,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_N     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clr,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             mismatch,
    output logic             locked,
    output logic             err_sticky,
    output logic             stuck,
    output logic             stuck_sticky
);

    localparam int unsigned LW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0] EXP_HIGH_W = (CNT_W + 1)'(EXP_HIGH);
    localparam logic [CNT_W:0] EXP_PERIOD_W = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0] TOL_W = (CNT_W + 1)'(TOL);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic             sig_prev_q, sig_prev_d;
    logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
    logic [CNT_W-1:0] per_acc_q, per_acc_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             mismatch_q, mismatch_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             err_sticky_q, err_sticky_d;
    logic             stuck_q, stuck_d;
    logic             stuck_sticky_q, stuck_sticky_d;

    logic             rise;
    logic [CNT_W:0]   hi_w, per_w, hi_dev, per_dev;
    logic             meas_mismatch;

    // Deviation taken one bit wider than the counters so it never wraps.
    always_comb begin
        hi_w          = {1'b0, hi_acc_q};
        per_w         = {1'b0, per_acc_q};
        hi_dev        = (hi_w >= EXP_HIGH_W) ? (hi_w - EXP_HIGH_W) : (EXP_HIGH_W - hi_w);
        per_dev       = (per_w >= EXP_PERIOD_W) ? (per_w - EXP_PERIOD_W) : (EXP_PERIOD_W - per_w);
        meas_mismatch = (hi_dev > TOL_W) || (per_dev > TOL_W);
    end

    always_comb begin
        rise         = sig_in & ~sig_prev_q;
        sig_prev_d   = sig_in;
        state_d      = state_q;
        hi_acc_d     = hi_acc_q;
        per_acc_d    = per_acc_q;
        meas_valid_d = 1'b0;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        mismatch_d   = 1'b0;
        lock_cnt_d   = lock_cnt_q;
        stuck_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    hi_acc_d  = CNT_W'(1);
                    per_acc_d = CNT_W'(1);
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (rise) begin
                    meas_valid_d = 1'b1;
                    high_cnt_d   = hi_acc_q;
                    period_cnt_d = per_acc_q;
                    mismatch_d   = meas_mismatch;
                    hi_acc_d     = CNT_W'(1);
                    per_acc_d    = CNT_W'(1);
                    if (meas_mismatch) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q != LOCK_MAX) begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end
                end else if (per_acc_q == CNT_MAX) begin
                    // No rise for a full counter span: give up and wait to re-arm.
                    stuck_d    = 1'b1;
                    lock_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    per_acc_d = per_acc_q + CNT_W'(1);
                    if (sig_in && (hi_acc_q != CNT_MAX)) begin
                        hi_acc_d = hi_acc_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        locked_d       = (lock_cnt_d == LOCK_MAX);
        // A set in the same cycle as clr takes priority.
        err_sticky_d   = mismatch_d | (err_sticky_q & ~clr);
        stuck_sticky_d = stuck_d | (stuck_sticky_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            sig_prev_q     <= 1'b1;
            hi_acc_q       <= '0;
            per_acc_q      <= '0;
            meas_valid_q   <= 1'b0;
            high_cnt_q     <= '0;
            period_cnt_q   <= '0;
            mismatch_q     <= 1'b0;
            lock_cnt_q     <= '0;
            locked_q       <= 1'b0;
            err_sticky_q   <= 1'b0;
            stuck_q        <= 1'b0;
            stuck_sticky_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sig_prev_q     <= sig_prev_d;
            hi_acc_q       <= hi_acc_d;
            per_acc_q      <= per_acc_d;
            meas_valid_q   <= meas_valid_d;
            high_cnt_q     <= high_cnt_d;
            period_cnt_q   <= period_cnt_d;
            mismatch_q     <= mismatch_d;
            lock_cnt_q     <= lock_cnt_d;
            locked_q       <= locked_d;
            err_sticky_q   <= err_sticky_d;
            stuck_q        <= stuck_d;
            stuck_sticky_q <= stuck_sticky_d;
        end
    end

    assign meas_valid   = meas_valid_q;
    assign high_cnt     = high_cnt_q;
    assign period_cnt   = period_cnt_q;
    assign mismatch     = mismatch_q;
    assign locked       = locked_q;
    assign err_sticky   = err_sticky_q;
    assign stuck        = stuck_q;
    assign stuck_sticky = stuck_sticky_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Bench for duty_cycle_meter: two parameterisations share one stimulus stream and are
// compared every cycle against a timestamp-based model, plus hand-computed expectations.
module tb_duty_cycle_meter;

    localparam int A_W   = 4;
    localparam int B_W   = 5;
    localparam int A_MAX = (1 << A_W) - 1;
    localparam int B_MAX = (1 << B_W) - 1;
    localparam int A_TOL = 0;
    localparam int B_TOL = 1;
    localparam int A_LN  = 4;
    localparam int B_LN  = 3;
    localparam int EH    = 1;
    localparam int EP    = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sig_in = 1'b0;
    logic clr = 1'b0;

    logic           mv_a, mm_a, lk_a, err_a, st_a, sts_a;
    logic [A_W-1:0] hc_a, pc_a;
    logic           mv_b, mm_b, lk_b, err_b, st_b, sts_b;
    logic [B_W-1:0] hc_b, pc_b;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int mcyc    = 0;

    // Model state per instance: timestamps and running counts, no register mirroring.
    int m_prev[2], m_run[2], m_last[2], m_hs[2];
    int m_mv[2], m_hc[2], m_pc[2], m_mm[2], m_lc[2], m_lk[2], m_err[2], m_st[2], m_sts[2];

    always #5 clk = ~clk;

    duty_cycle_meter #(
        .CNT_W(A_W), .EXP_HIGH(EH), .EXP_PERIOD(EP), .TOL(A_TOL), .LOCK_N(A_LN)
    ) dut_a (
        .clk(clk), .reset(reset), .sig_in(sig_in), .clr(clr),
        .meas_valid(mv_a), .high_cnt(hc_a), .period_cnt(pc_a), .mismatch(mm_a),
        .locked(lk_a), .err_sticky(err_a), .stuck(st_a), .stuck_sticky(sts_a)
    );

    duty_cycle_meter #(
        .CNT_W(B_W), .EXP_HIGH(EH), .EXP_PERIOD(EP), .TOL(B_TOL), .LOCK_N(B_LN)
    ) dut_b (
        .clk(clk), .reset(reset), .sig_in(sig_in), .clr(clr),
        .meas_valid(mv_b), .high_cnt(hc_b), .period_cnt(pc_b), .mismatch(mm_b),
        .locked(lk_b), .err_sticky(err_b), .stuck(st_b), .stuck_sticky(sts_b)
    );

    function automatic int p_max(input int d);
        return (d == 0) ? A_MAX : B_MAX;
    endfunction

    function automatic int p_tol(input int d);
        return (d == 0) ? A_TOL : B_TOL;
    endfunction

    function automatic int p_ln(input int d);
        return (d == 0) ? A_LN : B_LN;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic chk(input string name, input int at, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, at, act, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_prev[d] = 1; m_run[d] = 0; m_last[d] = 0; m_hs[d] = 0;
            m_mv[d] = 0; m_hc[d] = 0; m_pc[d] = 0; m_mm[d] = 0; m_lc[d] = 0;
            m_lk[d] = 0; m_err[d] = 0; m_st[d] = 0; m_sts[d] = 0;
        end
    endtask

    // c is a free-running cycle stamp; period = cycles between rises, saturated.
    task automatic model_step(input int d, input int s, input int cl, input int c);
        int rise;
        rise = (s == 1 && m_prev[d] == 0) ? 1 : 0;
        m_prev[d] = s;
        m_mv[d] = 0; m_mm[d] = 0; m_st[d] = 0;
        if (m_run[d] != 0) begin
            if (rise != 0) begin
                m_mv[d] = 1;
                m_hc[d] = imin(m_hs[d], p_max(d));
                m_pc[d] = imin(c - m_last[d], p_max(d));
                m_mm[d] = (absd(m_hc[d], EH) > p_tol(d) || absd(m_pc[d], EP) > p_tol(d)) ? 1 : 0;
                m_lc[d] = (m_mm[d] != 0) ? 0 : imin(m_lc[d] + 1, p_ln(d));
                m_lk[d] = (m_lc[d] == p_ln(d)) ? 1 : 0;
                m_last[d] = c;
                m_hs[d] = 1;
            end else if (c - m_last[d] >= p_max(d)) begin
                m_st[d] = 1; m_run[d] = 0; m_lc[d] = 0; m_lk[d] = 0;
            end else begin
                m_hs[d] += s;
            end
        end else if (rise != 0) begin
            m_run[d] = 1; m_last[d] = c; m_hs[d] = 1;
        end
        m_err[d] = (m_mm[d] != 0 || (m_err[d] != 0 && cl == 0)) ? 1 : 0;
        m_sts[d] = (m_st[d] != 0 || (m_sts[d] != 0 && cl == 0)) ? 1 : 0;
    endtask

    task automatic compare();
        chk("a.meas_valid", mcyc, 32'(mv_a), m_mv[0]);
        chk("a.high_cnt", mcyc, 32'(hc_a), m_hc[0]);
        chk("a.period_cnt", mcyc, 32'(pc_a), m_pc[0]);
        chk("a.mismatch", mcyc, 32'(mm_a), m_mm[0]);
        chk("a.locked", mcyc, 32'(lk_a), m_lk[0]);
        chk("a.err_sticky", mcyc, 32'(err_a), m_err[0]);
        chk("a.stuck", mcyc, 32'(st_a), m_st[0]);
        chk("a.stuck_sticky", mcyc, 32'(sts_a), m_sts[0]);
        chk("b.meas_valid", mcyc, 32'(mv_b), m_mv[1]);
        chk("b.high_cnt", mcyc, 32'(hc_b), m_hc[1]);
        chk("b.period_cnt", mcyc, 32'(pc_b), m_pc[1]);
        chk("b.mismatch", mcyc, 32'(mm_b), m_mm[1]);
        chk("b.locked", mcyc, 32'(lk_b), m_lk[1]);
        chk("b.err_sticky", mcyc, 32'(err_b), m_err[1]);
        chk("b.stuck", mcyc, 32'(st_b), m_st[1]);
        chk("b.stuck_sticky", mcyc, 32'(sts_b), m_sts[1]);
    endtask

    // Per-cycle checker: outputs sampled 1 time unit after the edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
                #1;
                compare();
            end else begin
                #1;
                mcyc++;
                for (int d = 0; d < 2; d++) model_step(d, int'(sig_in), int'(clr), mcyc);
                compare();
            end
        end
    end

    task automatic chk_zero(input string name);
        chk({name, ".a_outs"}, cyc, 32'({mv_a, hc_a, pc_a, mm_a, lk_a, err_a, st_a, sts_a}), 0);
        chk({name, ".b_outs"}, cyc, 32'({mv_b, hc_b, pc_b, mm_b, lk_b, err_b, st_b, sts_b}), 0);
    endtask

    // Leaves time at posedge+2 of cycle 0, with cycle 1 outputs visible.
    task automatic start_phase(input logic s0);
        @(negedge clk);
        reset = 1'b0; sig_in = 1'b0; clr = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; sig_in = s0;
        @(posedge clk);
        #2;
        cyc = 1;
    endtask

    task automatic run_cycle(input logic s, input logic c);
        @(negedge clk);
        sig_in = s; clr = c;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        int pat[9];
        pat = '{1, 1, 1, 0, 1, 0, 0, 0, 1};

        // Nominal 1,0,0,0 from cycle 0.
        start_phase(1'b1);
        for (int k = 1; k < 24; k++) begin
            run_cycle(k % 4 == 0, 1'b0);
            if (cyc == 5) chk("nom.arm_no_meas", cyc, 32'(mv_a), 0);
            if (cyc == 9 || cyc == 13 || cyc == 17 || cyc == 21) begin
                chk("nom.mv", cyc, 32'(mv_a), 1);
                chk("nom.high", cyc, 32'(hc_a), 1);
                chk("nom.period", cyc, 32'(pc_a), 4);
                chk("nom.mismatch", cyc, 32'(mm_a), 0);
            end
            if (cyc == 20) chk("nom.not_locked", cyc, 32'(lk_a), 0);
            if (cyc == 21) chk("nom.locked", cyc, 32'(lk_a), 1);
            if (cyc == 24) chk("nom.err", cyc, 32'(err_a), 0);
        end

        // Async reset between edges while locked, then release with sig_in high.
        chk("async.locked_before", cyc, 32'(lk_a), 1);
        #1 reset = 1'b0;
        #1 chk_zero("async");
        @(negedge clk);
        reset = 1'b1; sig_in = 1'b1; clr = 1'b0;
        @(posedge clk);
        #2;
        cyc = 1;
        for (int k = 1; k < 9; k++) begin
            run_cycle(pat[k] != 0, 1'b0);
            if (cyc < 9) chk("async.no_meas", cyc, 32'(mv_a), 0);
            if (cyc == 9) begin
                chk("async.first_meas", cyc, 32'(mv_a), 1);
                chk("async.period", cyc, 32'(pc_a), 4);
            end
        end

        // Wrong duty, then a 6-cycle period to break lock on the tolerant instance.
        start_phase(1'b1);
        for (int k = 1; k < 42; k++) begin
            logic s;
            if (k < 20) s = (k % 4 < 2);
            else if (k < 26) s = (k == 20);
            else s = ((k - 26) % 4 < 2);
            run_cycle(s, 1'b0);
            if (cyc == 9) begin
                chk("duty.a_high", cyc, 32'(hc_a), 2);
                chk("duty.a_period", cyc, 32'(pc_a), 4);
                chk("duty.a_mismatch", cyc, 32'(mm_a), 1);
                chk("duty.a_err", cyc, 32'(err_a), 1);
                chk("duty.b_mismatch", cyc, 32'(mm_b), 0);
            end
            if (cyc == 17) begin
                chk("tol.b_locked", cyc, 32'(lk_b), 1);
                chk("tol.b_err", cyc, 32'(err_b), 0);
            end
            if (cyc == 27) begin
                chk("tol.b_mv", cyc, 32'(mv_b), 1);
                chk("tol.b_high", cyc, 32'(hc_b), 1);
                chk("tol.b_period", cyc, 32'(pc_b), 6);
                chk("tol.b_mismatch", cyc, 32'(mm_b), 1);
                chk("tol.b_unlocked", cyc, 32'(lk_b), 0);
            end
            if (cyc == 35) chk("tol.b_relock_pending", cyc, 32'(lk_b), 0);
            if (cyc == 39) begin
                chk("tol.b_relocked", cyc, 32'(lk_b), 1);
                chk("duty.a_never_locked", cyc, 32'(lk_a), 0);
            end
        end

        // Stuck, re-arm, clr collision, then clr alone.
        start_phase(1'b0);
        for (int k = 1; k < 48; k++) begin
            run_cycle(k == 1 || k == 35 || k == 39 || k == 40 || k == 43, k == 43 || k == 46);
            if (cyc == 16) chk("stuck.a_early", cyc, 32'(st_a), 0);
            if (cyc == 17) begin
                chk("stuck.a_pulse", cyc, 32'(st_a), 1);
                chk("stuck.a_sticky", cyc, 32'(sts_a), 1);
            end
            if (cyc == 18) begin
                chk("stuck.a_one_shot", cyc, 32'(st_a), 0);
                chk("stuck.a_sticky_hold", cyc, 32'(sts_a), 1);
            end
            if (cyc == 32) chk("stuck.b_early", cyc, 32'(st_b), 0);
            if (cyc == 33) chk("stuck.b_pulse", cyc, 32'(st_b), 1);
            if (cyc == 36) begin
                chk("rearm.a_no_meas", cyc, 32'(mv_a), 0);
                chk("rearm.b_no_meas", cyc, 32'(mv_b), 0);
            end
            if (cyc == 40) begin
                chk("rearm.a_mv", cyc, 32'(mv_a), 1);
                chk("rearm.a_period", cyc, 32'(pc_a), 4);
                chk("rearm.a_high", cyc, 32'(hc_a), 1);
            end
            if (cyc == 44) begin
                chk("clr.a_mismatch", cyc, 32'(mm_a), 1);
                chk("clr.a_err_set_wins", cyc, 32'(err_a), 1);
                chk("clr.a_stuck_cleared", cyc, 32'(sts_a), 0);
                chk("clr.b_stuck_cleared", cyc, 32'(sts_b), 0);
            end
            if (cyc == 46) chk("clr.a_err_hold", cyc, 32'(err_a), 1);
            if (cyc == 47) chk("clr.a_err_cleared", cyc, 32'(err_a), 0);
        end

        // Randomized bursts with occasional long lows, random clr and async resets.
        start_phase(1'b0);
        for (int n = 0; n < 3000; ) begin
            int h, l;
            h = $urandom_range(1, 3);
            l = $urandom_range(1, 6);
            if ($urandom_range(0, 19) == 0) l = $urandom_range(10, 40);
            for (int i = 0; i < h; i++) run_cycle(1'b1, $urandom_range(0, 15) == 0);
            for (int i = 0; i < l; i++) run_cycle(1'b0, $urandom_range(0, 15) == 0);
            n += h + l;
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/duty_cycle_meter.md
Name: duty_cycle_meter

Overview:
Downstream consumer of the pulse generator. Samples the generator's single-bit output, which is synchronous to clk. Measures high time and period (rising edge to rising edge) in clk cycles and compares each measurement against the expected values within a tolerance. Reports per-period results, a lock indication, and sticky error/stuck flags for the top-level pass/fail logic.

Parameters:
CNT_W, 16, width of the high/period counters and the published results
EXP_HIGH, 1, expected high time in cycles
EXP_PERIOD, 4, expected period in cycles
TOL, 0, allowed absolute deviation, applied separately to high and period
LOCK_N, 4, consecutive matching periods required to assert locked

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous reset, active-low (asserted when 0)
sig_in  input  1  monitored waveform, synchronous to clk
clr  input  1  synchronous clear of err_sticky and stuck_sticky
meas_valid  output  1  one-cycle pulse; high_cnt/period_cnt/mismatch valid
high_cnt  output  CNT_W  high cycles of the last complete period
period_cnt  output  CNT_W  total cycles of the last complete period
mismatch  output  1  qualified by meas_valid; measurement outside tolerance
locked  output  1  LOCK_N consecutive in-tolerance periods seen
err_sticky  output  1  set on any mismatch; held until clr
stuck  output  1  one-cycle pulse; no rising edge for 2^CNT_W-1 cycles
stuck_sticky  output  1  set with stuck; held until clr

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; counters 0; lock count 0.
  - sig_prev=1, so a signal already high at release is not a rise.
  - State goes to IDLE.
  - Same behaviour when reset is asserted mid-operation.
- Rise: cycle where sig_in=1 and sig_prev=0. sig_prev <= sig_in every cycle.
- FSM states: IDLE, RUN.
  - IDLE: counters held. On rise: hi_acc=1, per_acc=1, go to RUN. Nothing is published.
  - RUN, rise cycle:
    - Publish hi_acc and per_acc to high_cnt/period_cnt; meas_valid=1 in the next cycle.
    - Reload hi_acc=1, per_acc=1.
  - RUN, no rise: per_acc += 1 (saturating at 2^CNT_W-1); hi_acc += sig_in (saturating).
  - RUN, no rise and per_acc == 2^CNT_W-1: stuck=1 and stuck_sticky=1 next cycle; locked=0; lock count 0; go to IDLE.
  - A rise takes priority over stuck in the same cycle; a period equal to the maximum is published normally.
- Latency: a rise sampled in cycle k gives meas_valid, high_cnt, period_cnt, mismatch and the locked update all in cycle k+1.
- high_cnt/period_cnt hold their values between meas_valid pulses.
- Mismatch:
  - mismatch = (|high - EXP_HIGH| > TOL) or (|period - EXP_PERIOD| > TOL).
  - Compare unsigned at CNT_W+1 bits with no wrap.
  - mismatch is 0 whenever meas_valid=0.
- Lock:
  - Lock count increments on each in-tolerance measurement, saturating at LOCK_N.
  - A mismatch clears the count and forces locked=0.
  - locked=1 in the same cycle the count reaches LOCK_N.
- Sticky flags:
  - err_sticky sets on mismatch; stuck_sticky sets on stuck.
  - clr clears both.
  - A set in the same cycle as clr wins (flag reads 1).
- Glitches: any extra 0->1 transition is a rise and ends the period; no filtering.

Test Plan:
- Nominal 25% duty. Release reset, drive sig_in 1,0,0,0 repeating from cycle 0.
  - Cycle 0 is not a rise; cycle 4 rise arms the meter.
  - meas_valid in cycles 9, 13, 17, 21 with high_cnt=1, period_cnt=4, mismatch=0.
  - locked=1 from cycle 21; err_sticky stays 0.
- Wrong duty, TOL=0. Pattern 1,1,0,0 after arming.
  - Each meas_valid shows high_cnt=2, period_cnt=4, mismatch=1.
  - err_sticky=1; locked stays 0.
- Tolerance and lock break. TOL=1, pattern 1,1,0,0 gives mismatch=0.
  - Then one period 1,0,0,0,0,0 (period 6) gives mismatch=1, locked drops to 0 and the lock count restarts.
- Stuck, CNT_W=4. Hold sig_in=0 after a rise in cycle t.
  - stuck pulse in cycle t+16; stuck_sticky=1; FSM returns to IDLE.
  - The next rise only re-arms: no meas_valid for that rise.
- clr collision. Assert clr in the same cycle a mismatch is registered: err_sticky=1.
  - clr alone in a later cycle: err_sticky=0 and stuck_sticky=0 the following cycle.
- Async reset mid-period. Pull reset low between two clk edges while locked=1.
  - All outputs 0 immediately.
  - After release with sig_in high: no rise until sig_in goes 0 then 1.
